// File: rtl/display_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// display_scroll_ctrl
//
// Shows a 4-digit window of an 8-digit hex message, either as a fixed view
// (offset 0) or as a circular marquee that advances one digit every
// STEP_CYCLES clocks. Selected display positions can be blanked on a
// BLINK_CYCLES half-period so they blink.
//
// Ports
//   clk          system clock (only clock)
//   rst          asynchronous, active-high reset
//   load         request to load a new message
//   load_data    eight hex digits, digit k = load_data[4k+3:4k]
//   load_points  decimal point per digit, bit k = digit k
//   ready        high when a load request would be accepted this cycle
//   mode         0 = static window, 1 = scrolling window
//   pause        freezes the scroll step counter and the window offset
//   blink_mask   display positions that blink
//   hexs         window digits, position i = hexs[4i+3:4i]
//   points       window decimal points
//   LEs          per-position blank (1 = blanked)
//   offset       current window offset
// ---------------------------------------------------------------------------
module display_scroll_ctrl #(
  parameter int STEP_CYCLES  = 25000000,
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_points,
  output logic        ready,
  input  logic        mode,
  input  logic        pause,
  input  logic [3:0]  blink_mask,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic [2:0]  offset
);

  // Counters only ever hold 0..N-1, so clog2(N) bits is enough.
  localparam int STEP_W  = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STATIC = 2'd2,
    SCROLL = 2'd3
  } state_t;

  state_t               state_reg;
  logic [31:0]          digits_reg;
  logic [7:0]           dp_reg;
  logic [2:0]           o_reg;
  logic [STEP_W-1:0]    step_reg;
  logic [BLINK_W-1:0]   blink_reg;
  logic                 blink_phase_reg;

  logic                 accept;
  logic                 step_done;
  logic                 blink_done;
  logic [15:0]          win_hex;
  logic [3:0]           win_dp;

  assign ready      = (state_reg != LOAD);
  assign accept     = load && ready;
  assign step_done  = (step_reg == STEP_LAST);
  assign blink_done = (blink_reg == BLINK_LAST);

  // Window selection: position i shows buffer digit (o + i) mod 8. The 3-bit
  // sum wraps naturally, which gives the circular view.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
      logic [2:0] idx;
      assign idx                 = o_reg + 3'(gi);
      assign win_hex[4*gi +: 4]  = digits_reg[{idx, 2'b00} +: 4];
      assign win_dp[gi]          = dp_reg[idx];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      digits_reg      <= '0;
      dp_reg          <= '0;
      o_reg           <= '0;
      step_reg        <= '0;
      blink_reg       <= '0;
      blink_phase_reg <= 1'b0;
      hexs            <= '0;
      points          <= '0;
      LEs             <= 4'hF;
      offset          <= '0;
    end else begin
      // Display outputs are a registered image of the current state, so
      // they trail any state/counter change by one clock.
      if (state_reg == IDLE) begin
        hexs   <= '0;
        points <= '0;
        LEs    <= 4'hF;
        offset <= '0;
      end else begin
        hexs   <= win_hex;
        points <= win_dp;
        LEs    <= blink_mask & {4{blink_phase_reg}};
        offset <= o_reg;
      end

      // Blink timebase: free-running outside IDLE, restarted by a load,
      // deliberately unaffected by pause.
      if (state_reg == LOAD) begin
        blink_reg <= '0;
      end else if (state_reg != IDLE) begin
        if (blink_done) begin
          blink_reg       <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_reg <= blink_reg + BLINK_W'(1);
        end
      end

      case (state_reg)
        IDLE: begin
          if (accept) state_reg <= LOAD;
        end

        LOAD: begin
          digits_reg <= load_data;
          dp_reg     <= load_points;
          o_reg      <= '0;
          step_reg   <= '0;
          state_reg  <= mode ? SCROLL : STATIC;
        end

        STATIC: begin
          o_reg    <= '0;
          step_reg <= '0;
          if (accept)    state_reg <= LOAD;
          else if (mode) state_reg <= SCROLL;
        end

        SCROLL: begin
          // A load wins over everything else; the pending step is dropped
          // because LOAD restarts the window anyway.
          if (accept) begin
            state_reg <= LOAD;
          end else if (!mode) begin
            state_reg <= STATIC;
            o_reg     <= '0;
            step_reg  <= '0;
          end else if (!pause) begin
            if (step_done) begin
              step_reg <= '0;
              o_reg    <= o_reg + 3'd1;
            end else begin
              step_reg <= step_reg + STEP_W'(1);
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scroll_ctrl
//
// Bench for display_scroll_ctrl with STEP_CYCLES=4, BLINK_CYCLES=8.
// A table of {inputs, cycle count, expected outputs} drives the main
// sequence; a cycle-level reference model pushes the expected registered
// outputs into a queue at each clock edge and they are popped and compared
// half a cycle later. Hand-written sequences cover load/step collision,
// blink timing and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_display_scroll_ctrl;

  localparam int STEP  = 4;
  localparam int BLINK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_data = '0;
  logic [7:0]  load_points = '0;
  logic        mode = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic        ready;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  LEs;
  logic [2:0]  offset;

  display_scroll_ctrl #(
    .STEP_CYCLES (STEP),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_points(load_points),
    .ready      (ready),
    .mode       (mode),
    .pause      (pause),
    .blink_mask (blink_mask),
    .hexs       (hexs),
    .points     (points),
    .LEs        (LEs),
    .offset     (offset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
    logic [2:0]  offset;
  } exp_t;

  exp_t sb_q[$];

  // ---------------- reference model ----------------
  localparam int S_IDLE   = 0;
  localparam int S_LOAD   = 1;
  localparam int S_STATIC = 2;
  localparam int S_SCROLL = 3;

  int          m_state;
  logic [31:0] m_data;
  logic [7:0]  m_pts;
  int          m_o;
  int          m_step;
  int          m_blink;
  logic        m_phase;

  task automatic model_reset();
    m_state = S_IDLE;
    m_data  = '0;
    m_pts   = '0;
    m_o     = 0;
    m_step  = 0;
    m_blink = 0;
    m_phase = 1'b0;
    sb_q.delete();
  endtask

  // One rising edge of the model: record what the output registers capture,
  // then advance state.
  task automatic model_edge();
    exp_t        e;
    logic [63:0] dd;
    logic [15:0] pp;
    int          st;
    st = m_state;
    if (st == S_IDLE) begin
      e.hexs   = 16'h0000;
      e.points = 4'h0;
      e.les    = 4'hF;
      e.offset = 3'd0;
    end else begin
      dd       = {m_data, m_data} >> (4 * m_o);
      pp       = {m_pts, m_pts} >> m_o;
      e.hexs   = dd[15:0];
      e.points = pp[3:0];
      e.les    = blink_mask & {4{m_phase}};
      e.offset = 3'(m_o);
    end
    sb_q.push_back(e);

    if (st == S_STATIC || st == S_SCROLL) begin
      if (m_blink == BLINK - 1) begin
        m_blink = 0;
        m_phase = ~m_phase;
      end else begin
        m_blink = m_blink + 1;
      end
    end

    case (st)
      S_IDLE: if (load) m_state = S_LOAD;
      S_LOAD: begin
        m_data  = load_data;
        m_pts   = load_points;
        m_o     = 0;
        m_step  = 0;
        m_blink = 0;
        m_state = mode ? S_SCROLL : S_STATIC;
      end
      S_STATIC: begin
        if (load)      m_state = S_LOAD;
        else if (mode) m_state = S_SCROLL;
      end
      S_SCROLL: begin
        if (load) begin
          m_state = S_LOAD;
        end else if (!mode) begin
          m_state = S_STATIC;
          m_o     = 0;
          m_step  = 0;
        end else if (!pause) begin
          if (m_step == STEP - 1) begin
            m_step = 0;
            m_o    = (m_o + 1) % 8;
          end else begin
            m_step = m_step + 1;
          end
        end
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called at a negedge: drive inputs, check ready, clock once, compare.
  task automatic do_cycle(input logic ld, input logic [31:0] d, input logic [7:0] p,
                          input logic md, input logic ps, input logic [3:0] bm);
    exp_t e;
    load        = ld;
    load_data   = d;
    load_points = p;
    mode        = md;
    pause       = ps;
    blink_mask  = bm;
    #1;
    check("ready_model", 32'(ready), 32'(m_state != S_LOAD));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got 0 entries, expected 1");
    end else begin
      e = sb_q.pop_front();
      check("hexs_model",   32'(hexs),   32'(e.hexs));
      check("points_model", 32'(points), 32'(e.points));
      check("les_model",    32'(LEs),    32'(e.les));
      check("offset_model", 32'(offset), 32'(e.offset));
    end
  endtask

  // Hand-derived expectations after a multi-cycle segment.
  task automatic check_out(input string tag, input logic [15:0] xh, input logic [3:0] xp,
                           input logic [3:0] xl, input logic [2:0] xo, input logic xr);
    check({tag, "_hexs"},   32'(hexs),   32'(xh));
    check({tag, "_points"}, 32'(points), 32'(xp));
    check({tag, "_les"},    32'(LEs),    32'(xl));
    check({tag, "_offset"}, 32'(offset), 32'(xo));
    check({tag, "_ready"},  32'(ready),  32'(xr));
    $display("%s: hexs=%h points=%h LEs=%h offset=%0d ready=%b", tag, hexs, points, LEs, offset, ready);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ld;
    logic [31:0] d;
    logic [7:0]  p;
    logic        md;
    logic        ps;
    logic [3:0]  bm;
    int          n;
    logic [15:0] x_hexs;
    logic [3:0]  x_points;
    logic [3:0]  x_les;
    logic [2:0]  x_off;
    logic        x_ready;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic ld, input logic [31:0] d, input logic [7:0] p,
                              input logic md, input logic ps, input int n,
                              input logic [15:0] xh, input logic [3:0] xp, input logic [3:0] xl,
                              input logic [2:0] xo, input logic xr);
    vec_t v;
    v.ld = ld; v.d = d; v.p = p; v.md = md; v.ps = ps; v.bm = 4'h0; v.n = n;
    v.x_hexs = xh; v.x_points = xp; v.x_les = xl; v.x_off = xo; v.x_ready = xr;
    vt.push_back(v);
  endfunction

  localparam logic [31:0] DA = 32'h76543210;
  localparam logic [31:0] DB = 32'hFEDCBA98;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] scroll_hex [8];
    logic [3:0]  scroll_pts [8];

    scroll_hex = '{16'h3210, 16'h4321, 16'h5432, 16'h6543, 16'h7654, 16'h0765, 16'h1076, 16'h2107};
    scroll_pts = '{4'h5, 4'h2, 4'h9, 4'h4, 4'hA, 4'hD, 4'h6, 4'hB};

    // idle after reset
    add(0, 32'h0, 8'h00, 0, 0, 20, 16'h0000, 4'h0, 4'hF, 3'd0, 1);
    // static load: LOAD lasts one cycle, window appears one cycle after LOAD
    add(1, DA, 8'h00, 0, 0, 1,  16'h0000, 4'h0, 4'hF, 3'd0, 0);
    add(0, DA, 8'h00, 0, 0, 1,  16'h0000, 4'h0, 4'h0, 3'd0, 1);
    add(0, DA, 8'h00, 0, 0, 10, 16'h3210, 4'h0, 4'h0, 3'd0, 1);
    // reload in scrolling mode
    add(1, DA, 8'hA5, 1, 0, 1,  16'h3210, 4'h0, 4'h0, 3'd0, 0);
    add(0, DA, 8'hA5, 1, 0, 1,  16'h3210, 4'h0, 4'h0, 3'd0, 1);
    add(0, DA, 8'hA5, 1, 0, 5,  scroll_hex[1], scroll_pts[1], 4'h0, 3'd1, 1);
    for (int k = 2; k <= 8; k++)
      add(0, DA, 8'hA5, 1, 0, 4, scroll_hex[k % 8], scroll_pts[k % 8], 4'h0, 3'(k % 8), 1);
    // to o=2, then pause, then back to static
    add(0, DA, 8'hA5, 1, 0, 8,  16'h5432, 4'h9, 4'h0, 3'd2, 1);
    add(0, DA, 8'hA5, 1, 1, 10, 16'h5432, 4'h9, 4'h0, 3'd2, 1);
    add(0, DA, 8'hA5, 0, 1, 2,  16'h3210, 4'h5, 4'h0, 3'd0, 1);

    // ---- reset ----
    model_reset();
    #1 rst = 1'b1;
    #1 check_out("reset", 16'h0000, 4'h0, 4'hF, 3'd0, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      for (int c = 0; c < vt[i].n; c++)
        do_cycle(vt[i].ld, vt[i].d, vt[i].p, vt[i].md, vt[i].ps, vt[i].bm);
      check_out($sformatf("vec%0d", i), vt[i].x_hexs, vt[i].x_points, vt[i].x_les,
                vt[i].x_off, vt[i].x_ready);
    end

    // ---- load colliding with a step expiry at o=5 ----
    do_cycle(0, DA, 8'hA5, 1, 0, 4'h0);               // STATIC -> SCROLL
    for (int c = 0; c < 23; c++) do_cycle(0, DA, 8'hA5, 1, 0, 4'h0);
    check_out("pre_collide", 16'h0765, 4'hD, 4'h0, 3'd5, 1);
    do_cycle(1, DB, 8'h0F, 1, 0, 4'h0);               // accepted on expiry
    check_out("collide", 16'h0765, 4'hD, 4'h0, 3'd5, 0);
    do_cycle(1, DB, 8'h0F, 1, 0, 4'h0);               // load held in LOAD
    check_out("held_load", 16'h0765, 4'hD, 4'h0, 3'd5, 1);
    do_cycle(0, DB, 8'h0F, 1, 0, 4'h0);
    check_out("new_msg", 16'hBA98, 4'hF, 4'h0, 3'd0, 1);
    for (int c = 0; c < 4; c++) do_cycle(0, DB, 8'h0F, 1, 0, 4'h0);
    check_out("new_step", 16'hCBA9, 4'h7, 4'h0, 3'd1, 1);

    // ---- async reset mid-scroll ----
    #2 rst = 1'b1;
    #1 check_out("rst_scroll", 16'h0000, 4'h0, 4'hF, 3'd0, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) do_cycle(0, DB, 8'h0F, 1, 0, 4'h0);
    check_out("discarded", 16'h0000, 4'h0, 4'hF, 3'd0, 1);

    // ---- blink: LEs alternates every 8 cycles ----
    do_cycle(1, DA, 8'h00, 1, 0, 4'b0101);
    do_cycle(0, DA, 8'h00, 1, 0, 4'b0101);
    for (int c = 0; c < 8; c++) do_cycle(0, DA, 8'h00, 1, 0, 4'b0101);
    check(  "blink_off0", 32'(LEs), 32'h0);
    do_cycle(0, DA, 8'h00, 1, 0, 4'b0101);
    check(  "blink_on0",  32'(LEs), 32'h5);
    for (int c = 0; c < 7; c++) do_cycle(0, DA, 8'h00, 1, 0, 4'b0101);
    check(  "blink_on1",  32'(LEs), 32'h5);
    do_cycle(0, DA, 8'h00, 1, 0, 4'b0101);
    check(  "blink_off1", 32'(LEs), 32'h0);
    for (int c = 0; c < 7; c++) do_cycle(0, DA, 8'h00, 1, 0, 4'b0101);
    check(  "blink_off2", 32'(LEs), 32'h0);
    do_cycle(0, DA, 8'h00, 1, 0, 4'b0101);
    check(  "blink_on2",  32'(LEs), 32'h5);
    $display("blink: LEs=%h", LEs);

    // ---- async reset during LOAD ----
    do_cycle(1, DB, 8'hFF, 0, 0, 4'h0);
    check("in_load_ready", 32'(ready), 32'h0);
    #2 rst = 1'b1;
    #1 check_out("rst_load", 16'h0000, 4'h0, 4'hF, 3'd0, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) do_cycle(0, DB, 8'hFF, 0, 0, 4'h0);
    check_out("after_rst_load", 16'h0000, 4'h0, 4'hF, 3'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
